sm_key_debounce: RTL and testbench
==================================

// Module: sm_key_debounce
//
// PURPOSE
//   Debounces and conditions raw board push-buttons before they drive core controls
//   (run/step enable, clock-divide select) on sm_top. Each key passes through a
//   2-flop synchronizer and a per-key stability FSM. Outputs per key: a clean level
//   plus one-cycle press/release/auto-repeat strobes. Sits between the board key pins
//   and sm_top inputs in the board top level.
//
// PARAMETERS
//   WIDTH            2          number of independent keys
//   DEBOUNCE_CYCLES  1000000    clocks a new level must stay stable (10 ms @ 100 MHz); >= 2
//   ACTIVE_LOW       1          1: raw key reads 0 when pressed; 0: reads 1 when pressed
//   REPEAT_DELAY     50000000   clocks from press to first keyRepeat; 0 disables repeat
//   REPEAT_PERIOD    10000000   clocks between subsequent keyRepeat strobes; >= 1
//
// PORTS
//   clk         in   1      system clock
//   rst         in   1      asynchronous reset, active-high
//   keyIn       in   WIDTH  raw asynchronous key pins
//   keyLevel    out  WIDTH  debounced state, 1 = pressed (polarity-normalized)
//   keyPress    out  WIDTH  1-cycle strobe on debounced press
//   keyRelease  out  WIDTH  1-cycle strobe on debounced release
//   keyRepeat   out  WIDTH  1-cycle strobe while held (auto-repeat)
//
// BEHAVIOUR
// - One clock, one reset; async active-high rst forces all state immediately.
// - Reset values:
//   - keyLevel, keyPress, keyRelease, keyRepeat = 0.
//   - Sync flops = inactive level (ACTIVE_LOW ? 1 : 0).
//   - FSMs = RELEASED; all counters = 0.
// - Sync: sample = sync2 ^ ACTIVE_LOW (1 = pressed). Keys fully independent.
// - Per-key FSM, counter cnt (ceil(log2(DEBOUNCE_CYCLES)) bits):
//   RELEASED:     sample=1 -> PRESS_WAIT, cnt<=0
//   PRESS_WAIT:   sample=0 -> RELEASED (glitch, no strobe)
//                 cnt==D-1 -> PRESSED, keyLevel<=1, keyPress 1 cycle; else cnt++
//   PRESSED:      sample=0 -> RELEASE_WAIT, cnt<=0
//   RELEASE_WAIT: sample=1 -> PRESSED (no strobe)
//                 cnt==D-1 -> RELEASED, keyLevel<=0, keyRelease 1 cycle; else cnt++
// - Latency: a stable raw change appears on keyLevel D+3 edges after the first sampling
//   edge (counting that edge as 1). Strobes are registered, asserted in the same cycle
//   keyLevel changes.
// - Glitch handling:
//   - Any bounce shorter than D restarts qualification.
//   - Exactly one keyPress per debounced press, one keyRelease per debounced release.
// - Auto-repeat: repeat counter rcnt starts at 0 in the keyPress cycle.
//   - keyRepeat fires at REPEAT_DELAY, then every REPEAT_PERIOD, while keyLevel=1.
//   - rcnt keeps running in RELEASE_WAIT.
//   - rcnt clears and keyRepeat is forced 0 in the keyRelease cycle.
//   - REPEAT_DELAY=0: keyRepeat constant 0.
//   - rcnt must not wrap: it saturates/reloads, so no missed or extra strobe.
// - Simultaneous: keyPress and keyRepeat never share a cycle; a key never has
//   keyPress and keyRelease in the same cycle; different keys may strobe together.
// - Key held through reset release: qualifies as a fresh press after D+3 edges.
// - Reset mid-qualification: discards progress; no strobe is emitted for it.
//
// TESTING (WIDTH=2, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1, REPEAT_DELAY=10, REPEAT_PERIOD=3)
//   1. Reset, rst=1 with keyIn=2'b11
//      -> all outputs 0; after rst=0 and 50 idle cycles, no strobes.
//   2. keyIn[0] 1->0 clean, first sampled at edge E
//      -> keyLevel[0]=1 and keyPress[0]=1 after edge E+6.
//      -> keyPress[0] high exactly 1 cycle; key1 outputs stay 0.
//   3. keyIn[0] low 3 cycles, high 1, then low stable
//      -> exactly one keyPress[0], D+3 edges after the final fall; none earlier.
//   4. Hold key0 30 cycles past keyPress
//      -> keyRepeat[0] at offsets 10,13,16,19,22,25,28 (7 strobes).
//   5. While pressed: 2-cycle high blip, then stable high
//      -> blip gives no keyRelease and keyLevel stays 1.
//      -> stable high gives one keyRelease[0]; keyLevel and keyRepeat drop that cycle.
//   6. Assert rst during PRESS_WAIT
//      -> outputs 0 asynchronously; key released before rst=0 -> no strobes afterwards.

Source files
------------

// File: rtl/sm_key_debounce.sv
// Push-button conditioner: 2-flop synchronizer plus a per-key stability FSM that
// produces a clean pressed level and one-cycle press/release/auto-repeat strobes.
module sm_key_debounce #(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] keyIn,
  output logic [WIDTH-1:0] keyLevel,
  output logic [WIDTH-1:0] keyPress,
  output logic [WIDTH-1:0] keyRelease,
  output logic [WIDTH-1:0] keyRepeat
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int RMAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RCNT_W = $clog2(RMAX + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RCNT_W-1:0] R_DELAY   = RCNT_W'(REPEAT_DELAY);
  localparam logic [RCNT_W-1:0] R_PERIOD  = RCNT_W'(REPEAT_PERIOD);
  localparam bit                REPEAT_EN = (REPEAT_DELAY != 0);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_t;

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] sample;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= {WIDTH{ACTIVE_LOW}};
      sync2 <= {WIDTH{ACTIVE_LOW}};
    end else begin
      sync1 <= keyIn;
      sync2 <= sync1;
    end
  end

  // Normalize polarity so that 1 always means pressed downstream.
  assign sample = sync2 ^ {WIDTH{ACTIVE_LOW}};

  for (genvar k = 0; k < WIDTH; k++) begin : g_key
    key_state_t        state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [RCNT_W-1:0] rcnt, rcnt_n;
    logic [RCNT_W-1:0] rcnt_inc;
    logic [RCNT_W-1:0] r_target;
    logic              rphase, rphase_n;
    logic              level_q, level_n;
    logic              press_q, press_n;
    logic              release_q, release_n;
    logic              repeat_q, repeat_n;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state     <= RELEASED;
        cnt       <= '0;
        rcnt      <= '0;
        rphase    <= 1'b0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        repeat_q  <= 1'b0;
      end else begin
        state     <= state_n;
        cnt       <= cnt_n;
        rcnt      <= rcnt_n;
        rphase    <= rphase_n;
        level_q   <= level_n;
        press_q   <= press_n;
        release_q <= release_n;
        repeat_q  <= repeat_n;
      end
    end

    always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      rcnt_n    = rcnt;
      rphase_n  = rphase;
      level_n   = level_q;
      press_n   = 1'b0;
      release_n = 1'b0;
      repeat_n  = 1'b0;
      // rphase=0 waits for the initial delay, rphase=1 for each further period;
      // rcnt restarts at every strobe so it can never wrap.
      r_target  = rphase ? R_PERIOD : R_DELAY;
      rcnt_inc  = rcnt + RCNT_W'(1);

      case (state)
        RELEASED: begin
          if (sample[k]) begin
            state_n = PRESS_WAIT;
            cnt_n   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!sample[k]) begin
            state_n = RELEASED;
          end else if (cnt == CNT_LAST) begin
            state_n  = PRESSED;
            level_n  = 1'b1;
            press_n  = 1'b1;
            rcnt_n   = '0;
            rphase_n = 1'b0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        PRESSED, RELEASE_WAIT: begin
          if (REPEAT_EN) begin
            if (rcnt_inc == r_target) begin
              repeat_n = 1'b1;
              rcnt_n   = '0;
              rphase_n = 1'b1;
            end else begin
              rcnt_n = rcnt_inc;
            end
          end
          if (state == PRESSED) begin
            if (!sample[k]) begin
              state_n = RELEASE_WAIT;
              cnt_n   = '0;
            end
          end else if (sample[k]) begin
            state_n = PRESSED;
          end else if (cnt == CNT_LAST) begin
            // Release wins over a repeat that would land in the same cycle.
            state_n   = RELEASED;
            level_n   = 1'b0;
            release_n = 1'b1;
            repeat_n  = 1'b0;
            rcnt_n    = '0;
            rphase_n  = 1'b0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_n = RELEASED;
        end
      endcase
    end

    assign keyLevel[k]   = level_q;
    assign keyPress[k]   = press_q;
    assign keyRelease[k] = release_q;
    assign keyRepeat[k]  = repeat_q;
  end

endmodule

// File: tb/tb_sm_key_debounce.sv
// Bench for sm_key_debounce: directed key scenarios plus random bouncing keys,
// checked by a scoreboard fed from a run-length reference model.
module tb_sm_key_debounce;

  localparam int W   = 2;
  localparam int D   = 4;
  localparam int DLY = 10;
  localparam int PER = 3;
  localparam bit AL  = 1'b1;
  localparam int EW  = 19;  // {edge[15:0], key, kind[1:0]}

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] keyIn = '1;
  logic [W-1:0] keyLevel;
  logic [W-1:0] keyPress;
  logic [W-1:0] keyRelease;
  logic [W-1:0] keyRepeat;

  sm_key_debounce #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(D),
    .ACTIVE_LOW(AL),
    .REPEAT_DELAY(DLY),
    .REPEAT_PERIOD(PER)
  ) dut (
    .clk(clk),
    .rst(rst),
    .keyIn(keyIn),
    .keyLevel(keyLevel),
    .keyPress(keyPress),
    .keyRelease(keyRelease),
    .keyRepeat(keyRepeat)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int           n_tests = 0;
  int           n_fail  = 0;
  logic [EW-1:0] exp_q[$];
  logic [W-1:0] hist[$];
  logic [W-1:0] exp_lvl = '0;
  int           run[W];
  int           held[W];
  int           last_press_cyc[W];
  int           rep_count[W];
  int           fall_edge = 0;

  function automatic logic [EW-1:0] mk_ev(input int c, input int k, input int kind);
    logic [15:0] c16;
    logic        k1;
    logic [1:0]  kd;
    c16 = c[15:0];
    k1  = k[0];
    kd  = kind[1:0];
    return {c16, k1, kd};
  endfunction

  // Reference: the synchronizer delays the pressed value by two edges; the
  // level flips once the opposite value has been seen on D+1 consecutive edges.
  // Repeats fall on held = DLY, DLY+PER, DLY+2*PER, ... edges after the press.
  task automatic model_reset();
    hist.delete();
    hist.push_back('0);
    hist.push_back('0);
    exp_lvl = '0;
    for (int k = 0; k < W; k++) begin
      run[k]  = 0;
      held[k] = 0;
    end
    exp_q.delete();
  endtask

  task automatic apply(input logic [W-1:0] p);
    logic [W-1:0] s;
    int           tag;
    keyIn = AL ? ~p : p;
    tag   = cyc + 1;
    hist.push_back(p);
    s = hist.pop_front();
    for (int k = 0; k < W; k++) begin
      if (s[k] != exp_lvl[k]) run[k]++;
      else run[k] = 0;
      if (run[k] == D + 1) begin
        exp_lvl[k] = s[k];
        run[k]     = 0;
        if (s[k]) begin
          held[k] = 0;
          exp_q.push_back(mk_ev(tag, k, 0));
        end else begin
          exp_q.push_back(mk_ev(tag, k, 1));
        end
      end else if (exp_lvl[k]) begin
        held[k]++;
        if (DLY != 0 && (held[k] == DLY || (held[k] > DLY && (held[k] - DLY) % PER == 0)))
          exp_q.push_back(mk_ev(tag, k, 2));
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [W-1:0] p, input int n);
    repeat (n) begin
      @(negedge clk);
      apply(p);
    end
  endtask

  task automatic check_zero(input string name);
    n_tests++;
    if ({keyLevel, keyPress, keyRelease, keyRepeat} !== '0) begin
      n_fail++;
      $display("FAIL %s: outputs=%b expected all 0", name,
               {keyLevel, keyPress, keyRelease, keyRepeat});
    end
  endtask

  task automatic do_reset(input logic [W-1:0] hold_p, input int ncyc, input logic [W-1:0] after_p);
    @(negedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_zero("async_reset");
    keyIn = AL ? ~hold_p : hold_p;
    repeat (ncyc) @(negedge clk);
    rst = 1'b0;
    apply(after_p);
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always begin
    @(posedge clk);
    #1;
    for (int k = 0; k < W; k++) begin
      n_tests++;
      if (keyLevel[k] !== exp_lvl[k]) begin
        n_fail++;
        $display("FAIL level key%0d edge %0d: got %b expected %b", k, cyc, keyLevel[k], exp_lvl[k]);
      end
      for (int kind = 0; kind < 3; kind++) begin
        logic st;
        st = (kind == 0) ? keyPress[k] : (kind == 1) ? keyRelease[k] : keyRepeat[k];
        if (st !== 1'b0) begin
          if (kind == 0) last_press_cyc[k] = cyc;
          if (kind == 2) rep_count[k]++;
          n_tests++;
          if (exp_q.size() > 0 && exp_q[0] == mk_ev(cyc, k, kind)) begin
            void'(exp_q.pop_front());
          end else begin
            n_fail++;
            $display("FAIL strobe key%0d kind%0d edge %0d: got %b expected no strobe (queue head %h)",
                     k, kind, cyc, st, (exp_q.size() > 0) ? exp_q[0] : '0);
          end
        end
      end
    end
    while (exp_q.size() > 0 && int'(exp_q[0][EW-1:3]) <= cyc) begin
      n_tests++;
      n_fail++;
      $display("FAIL missed key%0d kind%0d at edge %0d: got no strobe expected 1",
               exp_q[0][2], exp_q[0][1:0], int'(exp_q[0][EW-1:3]));
      void'(exp_q.pop_front());
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] cur;
    int           len[W];
    for (int k = 0; k < W; k++) begin
      last_press_cyc[k] = -1000;
      rep_count[k]      = 0;
      len[k]            = 0;
    end
    cur = '0;

    // reset with keys idle, then quiet period
    keyIn = '1;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_zero("reset_state");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    apply(2'b00);
    drive(2'b00, 49);

    // clean press of key0, then clean release
    @(negedge clk);
    fall_edge = cyc + 1;
    apply(2'b01);
    drive(2'b01, 9);
    check_int("press_latency", last_press_cyc[0] - fall_edge, D + 2);
    drive(2'b00, 12);

    // bounce then stable press, held for auto-repeat
    last_press_cyc[0] = -1000;
    rep_count[0]      = 0;
    drive(2'b01, 3);
    drive(2'b00, 1);
    @(negedge clk);
    fall_edge = cyc + 1;
    apply(2'b01);
    drive(2'b01, 36);
    @(posedge clk);
    #2;
    check_int("bounce_press_latency", last_press_cyc[0] - fall_edge, D + 2);
    check_int("repeat_count", rep_count[0], 7);

    // release blip while pressed, then real release
    drive(2'b00, 2);
    drive(2'b01, 8);
    drive(2'b00, 14);

    // reset in the middle of key1 qualification, key let go during reset
    drive(2'b10, 3);
    do_reset(2'b00, 3, 2'b00);
    drive(2'b00, 20);

    // reset while key0 is pressed, key held through reset release
    drive(2'b01, 10);
    do_reset(2'b01, 3, 2'b01);
    drive(2'b01, 15);
    drive(2'b00, 12);

    // random bouncing keys with occasional resets
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < W; k++) begin
        if (len[k] == 0) begin
          cur[k] = 1'($urandom_range(0, 1));
          len[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 40))
                                               : int'($urandom_range(1, 6));
        end
        len[k]--;
      end
      if ($urandom_range(0, 499) == 0) begin
        do_reset(cur, int'($urandom_range(1, 4)), cur);
      end else begin
        @(negedge clk);
        apply(cur);
      end
    end
    drive(2'b00, 20);
    @(posedge clk);
    #2;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
